// File: rtl/timer_multimode.sv
// Multimode hour/min/sec timer: wall-clock count-up or countdown with expiry,
// with per-field adjustment driven by debounced one-shot button pulses.
module timer_multimode #(
  parameter int TICKS_PER_SEC = 100,
  parameter int CNT_W         = 7,
  parameter int HOUR_MAX      = 23
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       start_timer,
  input  logic       mode,
  input  logic       adjust_en,
  input  logic       unit_toggle_press_once,
  input  logic       time_increment_press_once,
  input  logic       time_decrement_press_once,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] adj_unit,
  output logic       running,
  output logic       expired
);

  typedef enum logic [2:0] {IDLE, RUN, ADJ_SEC, ADJ_MIN, ADJ_HOUR, EXPIRED} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [5:0]       HOUR_LAST = 6'(HOUR_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic             expired_q, expired_d;
  logic             tick, at_zero;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  function automatic logic [5:0] adjust(input logic [5:0] v, input logic [5:0] max,
                                        input logic inc, input logic dec);
    if (inc)      return wrap_inc(v, max);
    else if (dec) return wrap_dec(v, max);
    else          return v;
  endfunction

  function automatic logic is_adj(input state_e s);
    return (s == ADJ_SEC) || (s == ADJ_MIN) || (s == ADJ_HOUR);
  endfunction

  assign tick    = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign at_zero = (hour_q == 6'd0) && (min_q == 6'd0) && (sec_q == 6'd0);

  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!start_timer) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = RUN;
        RUN: begin
          if (adjust_en)                   state_d = ADJ_SEC;
          else if (tick && mode && at_zero) state_d = EXPIRED;
        end
        ADJ_SEC: begin
          if (!adjust_en)                  state_d = RUN;
          else if (unit_toggle_press_once) state_d = ADJ_MIN;
        end
        ADJ_MIN: begin
          if (!adjust_en)                  state_d = RUN;
          else if (unit_toggle_press_once) state_d = ADJ_HOUR;
        end
        ADJ_HOUR: begin
          if (!adjust_en)                  state_d = RUN;
          else if (unit_toggle_press_once) state_d = ADJ_SEC;
        end
        EXPIRED:  state_d = EXPIRED;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running  = (state_q == RUN);
    adj_unit = 2'b00;
    case (state_q)
      ADJ_SEC:  adj_unit = 2'b01;
      ADJ_MIN:  adj_unit = 2'b10;
      ADJ_HOUR: adj_unit = 2'b11;
      default:  adj_unit = 2'b00;
    endcase
  end

  // Datapath acts on the current state, so pulses landing on a transition hit the old field.
  always_comb begin
    cnt_d  = cnt_q;
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (state_q == RUN) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    if (is_adj(state_d) && !is_adj(state_q)) cnt_d = '0;

    if (tick) begin
      if (!mode) begin
        sec_d = wrap_inc(sec_q, 6'd59);
        if (sec_q == 6'd59) begin
          min_d = wrap_inc(min_q, 6'd59);
          if (min_q == 6'd59) hour_d = wrap_inc(hour_q, HOUR_LAST);
        end
      end else if (!at_zero) begin
        sec_d = wrap_dec(sec_q, 6'd59);
        if (sec_q == 6'd0) begin
          min_d = wrap_dec(min_q, 6'd59);
          if (min_q == 6'd0) hour_d = hour_q - 6'd1;
        end
      end
    end

    case (state_q)
      ADJ_SEC:  sec_d  = adjust(sec_q, 6'd59, time_increment_press_once, time_decrement_press_once);
      ADJ_MIN:  min_d  = adjust(min_q, 6'd59, time_increment_press_once, time_decrement_press_once);
      ADJ_HOUR: hour_d = adjust(hour_q, HOUR_LAST, time_increment_press_once, time_decrement_press_once);
      default:  ;
    endcase

    expired_d = (state_d == EXPIRED) && (state_q != EXPIRED);
  end

  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      hour_q    <= 6'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      expired_q <= expired_d;
    end
  end

  assign hour    = hour_q;
  assign min     = min_q;
  assign sec     = sec_q;
  assign expired = expired_q;

endmodule

// File: doc/timer_multimode.md
Name: timer_multimode

Overview:
- Parametrised successor to the team's 100 Hz clock/timer.
- Keeps a seconds/minutes/hours time value. Counts up (wall clock) or down (countdown with expiry), selected by `mode`.
- Seconds, minutes and hours are each adjustable via debounced one-shot button pulses.
- Sits between the button conditioning logic and the 7-segment display driver; `expired` feeds the buzzer/LED block.

Parameters:
- TICKS_PER_SEC, 100, clock cycles per second; sub-second counter wraps at TICKS_PER_SEC-1.
- CNT_W, 7, sub-second counter width; must satisfy 2^CNT_W >= TICKS_PER_SEC.
- HOUR_MAX, 23, highest hour value; 11 gives a 0..11 range. Wrap and borrow use this value.

Ports:
- clk_100Hz  in  1  system clock, nominal TICKS_PER_SEC Hz
- rst  in  1  asynchronous, active-high reset
- start_timer  in  1  level; 1 = enabled, 0 = hold/idle
- mode  in  1  0 = count up, 1 = count down
- adjust_en  in  1  level; 1 = adjust mode
- unit_toggle_press_once  in  1  one-cycle pulse; advances adjust unit
- time_increment_press_once  in  1  one-cycle pulse
- time_decrement_press_once  in  1  one-cycle pulse
- hour  out  6  0..HOUR_MAX
- min  out  6  0..59
- sec  out  6  0..59
- adj_unit  out  2  00 none, 01 sec, 10 min, 11 hour; combinational decode of state
- running  out  1  1 only in RUN
- expired  out  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset (async, rst=1): state=IDLE, hour=min=sec=0, sub-second counter=0, expired=0. Release is synchronous to clk_100Hz.
- States: IDLE, RUN, ADJ_SEC, ADJ_MIN, ADJ_HOUR, EXPIRED. Registered state, next-state is combinational.
- Transitions, in priority order per state:
  - Any state, start_timer=0 -> IDLE.
  - IDLE: start_timer=1 -> RUN.
  - RUN: adjust_en=1 -> ADJ_SEC; countdown reaching zero -> EXPIRED.
  - ADJ_x: adjust_en=0 -> RUN; toggle pulse -> next unit in the cycle SEC -> MIN -> HOUR -> SEC.
  - EXPIRED: stays until start_timer=0. adjust_en is ignored.
- IDLE: time and sub-second counter hold their values (pause semantics, no clear).
- RUN, sub-second counter:
  - Increments every cycle.
  - When it equals TICKS_PER_SEC-1, it resets to 0 and a one-second tick occurs in that same cycle.
- RUN, mode=0, on tick: sec+1; sec 59 -> 0 with carry to min; min 59 -> 0 with carry to hour; hour HOUR_MAX -> 0.
- RUN, mode=1, on tick:
  - Time 0:0:0: no change; state -> EXPIRED and expired=1 for exactly one cycle.
  - Otherwise: sec-1. If sec=0: sec=59 and borrow from min. If min=0: min=59 and borrow from hour.
  - The step from 0:0:1 to 0:0:0 does not expire. Expiry happens on the following tick.
- mode is sampled at each tick; a change mid-second takes effect at the next tick.
- Entering any ADJ_x state clears the sub-second counter. The counter holds while in ADJ_x, so the first second after adjustment is a full second.
- ADJ_x adjusts only the selected field:
  - Increment wraps max -> 0 (59 for sec/min, HOUR_MAX for hour).
  - Decrement wraps 0 -> max.
  - If increment and decrement pulse in the same cycle, increment wins.
  - Pulses in the cycle a transition is taken apply to the current (old) state's field.
- Toggle pulses outside ADJ_x, and inc/dec pulses outside ADJ_x, are ignored.
- EXPIRED: time holds at 0:0:0 and expired stays 0 after its one pulse. Re-arm by dropping start_timer: IDLE, then adjust or count up.
- Reset asserted mid-count or mid-adjust clears everything immediately; expired is forced to 0.
- Outputs are registered. Field changes become visible the cycle after the tick or pulse.

Test Plan (TICKS_PER_SEC=4 for all scenarios, HOUR_MAX=23 unless stated):
- Up-count wrap: preload 23:59:59 via adjust, mode=0, run 4 cycles -> 00:00:00, running=1, expired never 1.
- Countdown expiry: adjust to 0:0:2, mode=1, run -> 0:0:1 after 4 cycles, 0:0:0 after 8. expired pulses for one cycle at cycle 12; state EXPIRED; values hold for 20 more cycles.
- Borrow chain: 1:00:00 in mode=1, one tick -> 0:59:59.
- Adjust cycling and wrap:
  - adjust_en=1, adj_unit=01; dec at sec=0 -> 59.
  - Toggle -> adj_unit=10; inc at min=59 -> 0.
  - Toggle -> 11; dec at hour=0 -> 23.
  - Toggle -> 01.
  - Simultaneous inc+dec at sec=5 -> 6.
- Pause/hold: run up to 0:0:3 with counter at 2, drop start_timer for 10 cycles -> unchanged; re-assert -> next tick 2 cycles later.
- Async reset mid-run at 0:5:7 with expired pending -> all outputs 0 immediately without a clock edge; HOUR_MAX=11 rerun of the wrap test wraps 11:59:59 -> 0:0:0.
